// File: rtl/dot_product.sv
// dot_product: three-SRAM (A, B, O) lane-parallel dot-product engine.
// Words are loaded from the file buses, then a 4-stage pipeline
// (address, read, multiply, accumulate) sums A[i]*B[i] over all words into
// one accumulator per lane. The finished accumulator is written to O[0] so
// a later run can be seeded from it.
// Build option: define DOT_PRODUCT_DEBUG_EN to drive the test_r / test_w /
// test_data observation ports; otherwise they are tied to zero.
module dot_product #(
  parameter int Addr_Width           = 4,
  parameter int Ram_Depth            = 16,
  parameter int Para_Deg             = 2,
  parameter int Data_Width_In        = 8,
  parameter int Data_Width_Out       = 16,
  parameter int Nums_Data_in_bits    = 4,
  parameter int Nums_Pipeline_Stages = 4
) (
  input  logic                                clk,
  input  logic                                Mem_reset_n,
  input  logic                                Comp_reset,
  input  logic                                Mem_Index_reset,
  input  logic                                Computing,
  input  logic                                PE_reset,
  input  logic                                load_old_output,
  input  logic                                load_from_file,
  input  logic [2*Para_Deg*Data_Width_In-1:0] input_data_from_file,
  input  logic [Para_Deg*Data_Width_Out-1:0]  output_data_from_file,
  output logic [Para_Deg*Data_Width_Out-1:0]  result,
  output logic [Nums_Data_in_bits:0]          state,
  output logic [3*Addr_Width-1:0]             test_r,
  output logic [3*Addr_Width-1:0]             test_w,
  output logic [2*Para_Deg*Data_Width_In-1:0] test_data
);

  localparam int Nums_Data               = 1 << Nums_Data_in_bits;
  localparam int Total_Computation_Steps = Nums_Data + Nums_Pipeline_Stages - 1;
  localparam int Word_In                 = Para_Deg * Data_Width_In;
  localparam int Word_Out                = Para_Deg * Data_Width_Out;
  localparam int Prod_Width              = 2 * Data_Width_In;
  localparam int Step_Width              = Nums_Data_in_bits + 1;

  // Step counter landmarks: last step, the step whose edge lands the final
  // accumulation, and the first step that no longer issues a read address.
  localparam logic [Step_Width-1:0] Step_Last      = Step_Width'(Total_Computation_Steps);
  localparam logic [Step_Width-1:0] Step_Final_Add = Step_Width'(Total_Computation_Steps - 1);
  localparam logic [Step_Width-1:0] Step_Issue_End = Step_Width'(Nums_Data);
  localparam logic [Step_Width-1:0] Step_One       = Step_Width'(1);
  localparam logic [Addr_Width-1:0] Addr_Last      = Addr_Width'(Ram_Depth - 1);
  localparam logic [Addr_Width-1:0] Addr_One       = Addr_Width'(1);

  // Storage: A and B hold input words, O holds accumulator-width words.
  logic [Word_In-1:0]  mem_a_q [Ram_Depth];
  logic [Word_In-1:0]  mem_b_q [Ram_Depth];
  logic [Word_Out-1:0] mem_o_q [Ram_Depth];

  // Pointers and step counter.
  logic [Addr_Width-1:0] wp_q, wp_d;
  logic [Addr_Width-1:0] rp_q, rp_d;
  logic [Step_Width-1:0] state_q, state_d;

  // Pipeline: S1 address valid, S2 read word, S3 lane products, S4 acc.
  logic                           v1_q, v1_d;
  logic                           v2_q, v2_d;
  logic                           v3_q, v3_d;
  logic [Word_In-1:0]             a_q, a_d;
  logic [Word_In-1:0]             b_q, b_d;
  logic [Para_Deg*Prod_Width-1:0] prod_q, prod_d;
  logic [Word_Out-1:0]            acc_q, acc_d;

  // Control decodes.
  logic                load_en;
  logic                comp_adv;
  logic                o_final_we;
  logic [Word_Out-1:0] acc_base;

  // Load and compute are mutually exclusive; compute wins a same-cycle request.
  always_comb begin
    comp_adv   = Computing && (state_q < Step_Last);
    load_en    = load_from_file && !Computing;
    o_final_we = comp_adv && !Comp_reset && (state_q == Step_Final_Add);
  end

  // Next-state logic for pointers, step counter and the pipeline stages.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned -- otherwise a latch is inferred.
    wp_d     = wp_q;
    rp_d     = rp_q;
    state_d  = state_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    acc_base = acc_q;

    if (load_en) begin
      wp_d = (wp_q == Addr_Last) ? '0 : wp_q + Addr_One;
    end

    // Everything advances together; with Computing low the whole pipeline
    // freezes, which is what makes pause/resume lossless.
    if (comp_adv) begin
      state_d = state_q + Step_One;

      // S1: issue the read address for this step.
      v1_d = (state_q < Step_Issue_End);
      if (state_q < Step_Issue_End) begin
        rp_d = Addr_Width'(state_q);
      end

      // S2: register the A and B words at the issued address.
      v2_d = v1_q;
      a_d  = mem_a_q[rp_q];
      b_d  = mem_b_q[rp_q];

      // S3: unsigned lane products at full product width.
      v3_d = v2_q;
      for (int j = 0; j < Para_Deg; j++) begin
        prod_d[j*Prod_Width +: Prod_Width] =
          Prod_Width'(a_q[j*Data_Width_In +: Data_Width_In]) *
          Prod_Width'(b_q[j*Data_Width_In +: Data_Width_In]);
      end

      // S4: the first step optionally seeds from O[0]; products only add
      // once a valid word has reached this stage. Sums wrap at acc width.
      if ((state_q == '0) && load_old_output) begin
        acc_base = mem_o_q[0];
      end
      acc_d = acc_base;
      if (v3_q) begin
        for (int j = 0; j < Para_Deg; j++) begin
          acc_d[j*Data_Width_Out +: Data_Width_Out] =
            acc_base[j*Data_Width_Out +: Data_Width_Out] +
            Data_Width_Out'(prod_q[j*Prod_Width +: Prod_Width]);
        end
      end
    end

    // Clears are applied last so they override any same-cycle update.
    if (Comp_reset) begin
      state_d = '0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      v3_d    = 1'b0;
    end
    if (Mem_Index_reset) begin
      wp_d = '0;
      rp_d = '0;
    end
    if (PE_reset) begin
      acc_d = '0;
    end
  end

  // Pointer, counter and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!Mem_reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  // SRAM writes: file loads, plus the finished accumulator into O[0].
  always_ff @(posedge clk) begin
    if (!Mem_reset_n) begin
      // NOTE: these arrays are deliberately cleared on reset because a
      // zeroed O[0] and zeroed A/B words are visible behaviour; this keeps
      // them in flops rather than a RAM macro.
      for (int i = 0; i < Ram_Depth; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
        mem_o_q[i] <= '0;
      end
    end else begin
      if (load_en) begin
        mem_a_q[wp_q] <= input_data_from_file[Word_In-1:0];
        mem_b_q[wp_q] <= input_data_from_file[2*Word_In-1:Word_In];
      end
      if (o_final_we) begin
        mem_o_q[0] <= acc_d;
      end else if (load_en) begin
        mem_o_q[wp_q] <= output_data_from_file;
      end
    end
  end

  // Primary outputs.
  always_comb begin
    result = acc_q;
    state  = state_q;
  end

  // Observation ports: SRAM k occupies slot k (A, B, O); all share the
  // same pointers, so each slot carries the same value.
`ifdef DOT_PRODUCT_DEBUG_EN
  always_comb begin
    test_w    = {3{wp_q}};
    test_r    = {3{rp_q}};
    test_data = {b_q, a_q};
  end
`else
  always_comb begin
    test_w    = '0;
    test_r    = '0;
    test_data = '0;
  end
`endif

endmodule

// File: tb/tb_dot_product.sv
// Self-checking bench for dot_product: a table of load/compute vectors plus
// hand-written sequences for pause, saturation, pointer wrap, compute-over-
// load priority and reset mid-compute. Expected results go into a
// scoreboard queue when a compute run starts and are popped when the step
// counter reports completion.
module tb_dot_product;

  localparam int AW  = 4;
  localparam int PD  = 2;
  localparam int DWI = 8;
  localparam int DWO = 16;
  localparam int STEPS = 19;

  logic                   clk;
  logic                   Mem_reset_n;
  logic                   Comp_reset;
  logic                   Mem_Index_reset;
  logic                   Computing;
  logic                   PE_reset;
  logic                   load_old_output;
  logic                   load_from_file;
  logic [2*PD*DWI-1:0]    input_data_from_file;
  logic [PD*DWO-1:0]      output_data_from_file;
  logic [PD*DWO-1:0]      result;
  logic [4:0]             state;
  logic [3*AW-1:0]        test_r;
  logic [3*AW-1:0]        test_w;
  logic [2*PD*DWI-1:0]    test_data;

  dot_product #(
    .Addr_Width(AW), .Ram_Depth(16), .Para_Deg(PD), .Data_Width_In(DWI),
    .Data_Width_Out(DWO), .Nums_Data_in_bits(4), .Nums_Pipeline_Stages(4)
  ) dut (
    .clk(clk),
    .Mem_reset_n(Mem_reset_n),
    .Comp_reset(Comp_reset),
    .Mem_Index_reset(Mem_Index_reset),
    .Computing(Computing),
    .PE_reset(PE_reset),
    .load_old_output(load_old_output),
    .load_from_file(load_from_file),
    .input_data_from_file(input_data_from_file),
    .output_data_from_file(output_data_from_file),
    .result(result),
    .state(state),
    .test_r(test_r),
    .test_w(test_w),
    .test_data(test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          nwords;
    logic [7:0]  a0, a1, b0, b1;
    logic [15:0] o0, o1;
    logic        seed;
    logic [15:0] exp0, exp1;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] r0, r1;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_sum(input int n, input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    s = n * int'(a) * int'(b);
    return s[15:0];
  endfunction

  task automatic apply_reset(input int n);
    Mem_reset_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    Mem_reset_n = 1'b1;
  endtask

  task automatic load_words(input int n, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] o0, input logic [15:0] o1);
    for (int i = 0; i < n; i++) begin
      load_from_file        = 1'b1;
      input_data_from_file  = {b1, b0, a1, a0};
      output_data_from_file = {o1, o0};
      tick();
    end
    load_from_file = 1'b0;
  endtask

  // Clear accumulators and step counter ahead of a run.
  task automatic clear_run();
    Computing  = 1'b0;
    PE_reset   = 1'b1;
    Comp_reset = 1'b1;
    tick();
    PE_reset   = 1'b0;
    Comp_reset = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [15:0] r0, input logic [15:0] r1);
    exp_t e;
    e.name = name;
    e.r0   = r0;
    e.r1   = r1;
    sb.push_back(e);
  endtask

  // Run compute until the step counter reports completion (bounded), with
  // an optional pause; then pop the scoreboard and compare.
  task automatic run_compute(input int pause_at, input int pause_len);
    int   cyc;
    logic done;
    exp_t e;
    cyc  = 0;
    done = 1'b0;
    Computing = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (int'(state) == pause_at && pause_len > 0) begin
        Computing = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          check("pause_state_hold", 32'(state), 32'(pause_at));
        end
        Computing = 1'b1;
      end
      if (int'(state) == STEPS) begin
        done = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    check({e.name, "_done"}, 32'(done), 32'd1);
    check({e.name, "_latency"}, 32'(cyc), 32'(STEPS));
    check({e.name, "_state"}, 32'(state), 32'(STEPS));
    check({e.name, "_lane0"}, 32'(result[15:0]), 32'(e.r0));
    check({e.name, "_lane1"}, 32'(result[31:16]), 32'(e.r1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r0, r1;

    vecs[0] = '{"basic",        8,  8'd1,   8'd1,   8'd2,   8'd2,   16'd0,    16'd0,   1'b0, 16'd16,    16'd16};
    vecs[1] = '{"seeded",       8,  8'd1,   8'd1,   8'd2,   8'd2,   16'd100,  16'd100, 1'b1, 16'd116,   16'd116};
    vecs[2] = '{"acc_wrap",     16, 8'd255, 8'd255, 8'd255, 8'd255, 16'd0,    16'd0,   1'b0, 16'd57360, 16'd57360};
    vecs[3] = '{"lanes",        16, 8'd3,   8'd7,   8'd5,   8'd11,  16'd0,    16'd0,   1'b0, 16'd240,   16'd1232};
    vecs[4] = '{"seeded_lanes", 5,  8'd200, 8'd10,  8'd100, 8'd0,   16'd1000, 16'd7,   1'b1, 16'd35464, 16'd7};

    Mem_reset_n           = 1'b1;
    Comp_reset            = 1'b0;
    Mem_Index_reset       = 1'b0;
    Computing             = 1'b0;
    PE_reset              = 1'b0;
    load_old_output       = 1'b0;
    load_from_file        = 1'b0;
    input_data_from_file  = '0;
    output_data_from_file = '0;

    // Reset state.
    apply_reset(2);
    check("reset_result", result, 32'd0);
    check("reset_state", 32'(state), 32'd0);

    // Table-driven vectors; each is replayed seeded from O[0] to confirm
    // the finished accumulator was written there.
    for (int v = 0; v < 5; v++) begin
      apply_reset(2);
      load_words(vecs[v].nwords, vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1,
                 vecs[v].o0, vecs[v].o1);
      clear_run();
      load_old_output = vecs[v].seed;
      push_exp(vecs[v].name, vecs[v].exp0, vecs[v].exp1);
      run_compute(-1, 0);
      Computing       = 1'b0;
      load_old_output = 1'b0;

      clear_run();
      load_old_output = 1'b1;
      r0 = vecs[v].exp0 + lane_sum(vecs[v].nwords, vecs[v].a0, vecs[v].b0);
      r1 = vecs[v].exp1 + lane_sum(vecs[v].nwords, vecs[v].a1, vecs[v].b1);
      push_exp({vecs[v].name, "_o0_replay"}, r0, r1);
      run_compute(-1, 0);
      Computing       = 1'b0;
      load_old_output = 1'b0;
    end

    // Pause at step 5 for 3 cycles, then saturation hold.
    apply_reset(2);
    load_words(8, 8'd1, 8'd1, 8'd2, 8'd2, 16'd0, 16'd0);
    clear_run();
    push_exp("pause", 16'd16, 16'd16);
    run_compute(5, 3);
    for (int i = 0; i < 3; i++) tick();
    check("saturate_state", 32'(state), 32'(STEPS));
    check("saturate_result", result, {16'd16, 16'd16});
    Computing = 1'b0;

    // Write-pointer wrap: the 17th word overwrites A[0].
    apply_reset(2);
    load_words(16, 8'd1, 8'd1, 8'd1, 8'd1, 16'd0, 16'd0);
    load_words(1, 8'd9, 8'd9, 8'd1, 8'd1, 16'd0, 16'd0);
`ifdef DOT_PRODUCT_DEBUG_EN
    check("wp_wrap_test_w", 32'(test_w), 32'({3{4'd1}}));
`else
    check("debug_off_test_w", 32'(test_w), 32'd0);
`endif
    clear_run();
    push_exp("wp_wrap", 16'd24, 16'd24);
    run_compute(-1, 0);
`ifndef DOT_PRODUCT_DEBUG_EN
    check("debug_off_test_data", test_data, 32'd0);
`endif
    Computing = 1'b0;

    // Compute has priority over a same-cycle load request.
    apply_reset(2);
    load_words(1, 8'd2, 8'd2, 8'd3, 8'd3, 16'd0, 16'd0);
    clear_run();
    load_from_file       = 1'b1;
    input_data_from_file = {8'd50, 8'd50, 8'd50, 8'd50};
    push_exp("compute_over_load", 16'd6, 16'd6);
    run_compute(-1, 0);
    Computing      = 1'b0;
    load_from_file = 1'b0;

    // Comp_reset overrides increment; reset mid-compute aborts with no O write.
    apply_reset(2);
    load_words(16, 8'd1, 8'd1, 8'd1, 8'd1, 16'd0, 16'd0);
    clear_run();
    Computing = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    Comp_reset = 1'b1;
    tick();
    Comp_reset = 1'b0;
    check("comp_reset_state", 32'(state), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("mid_state_before_reset", 32'(state), 32'd10);
    Mem_reset_n = 1'b0;
    tick();
    Mem_reset_n = 1'b1;
    Computing   = 1'b0;
    check("abort_result", result, 32'd0);
    check("abort_state", 32'(state), 32'd0);
    clear_run();
    load_old_output = 1'b1;
    push_exp("abort_no_o_write", 16'd0, 16'd0);
    run_compute(-1, 0);
    Computing       = 1'b0;
    load_old_output = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product.md
DOT_PRODUCT -- requirements
Module: dot_product

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Addr_Width, 4, SRAM address bits.
- Ram_Depth, 16, words per SRAM.
- Para_Deg, 2, lanes per word.
- Data_Width_In, 8, input element width.
- Data_Width_Out, 16, output/accumulator width.
- Nums_Data_in_bits, 4, log2 of compute steps.
- Nums_Pipeline_Stages, 4, pipeline depth.
- Derived: Nums_SRAM_In=2, Nums_SRAM_Out=1, Nums_SRAM=3, Nums_Data=16, Total_Computation_Steps=Nums_Data+Nums_Pipeline_Stages-1=19.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- Mem_reset_n, in, 1, synchronous active-low reset.
- Comp_reset, in, 1, sync clear of step counter.
- Mem_Index_reset, in, 1, sync clear of read/write pointers.
- Computing, in, 1, compute enable.
- PE_reset, in, 1, sync clear of accumulators.
- load_old_output, in, 1, seed accumulators from output SRAM.
- load_from_file, in, 1, load enable.
- input_data_from_file, in, 2*Para_Deg*Data_Width_In; SRAM k lane j at bit k*Para_Deg*Data_Width_In + j*Data_Width_In.
- output_data_from_file, in, Para_Deg*Data_Width_Out; lane j at bit j*Data_Width_Out.
- result, out, Para_Deg*Data_Width_Out, lane j accumulator.
- state, out, Nums_Data_in_bits+1, compute step counter.
- test_r, out, Nums_SRAM*Addr_Width, per-SRAM read address.
- test_w, out, Nums_SRAM*Addr_Width, per-SRAM write address.
- test_data, out, 2*Para_Deg*Data_Width_In, input SRAM read data.

Function
REQ-003 Three SRAMs (A, B, O) of Ram_Depth words; each word holds Para_Deg lanes.
REQ-004 Load cycle (load_from_file=1, Computing=0):
- A[wp], B[wp] and O[wp] are written from the input buses.
- wp increments by 1 and wraps Ram_Depth-1 -> 0.
REQ-005 Computing=1 with load_from_file=1 at the same time: load is ignored and compute takes priority.
REQ-006 Compute runs while Computing=1 and state<Total_Computation_Steps. Each cycle:
- state increments.
- While state<Nums_Data, read address rp=state is issued to A and B.
REQ-007 Pipeline of exactly 4 stages:
- S1: issue address.
- S2: register A and B word.
- S3: register lane products A[j]*B[j], unsigned 8x8 to 16 bits.
- S4: acc[j] += product, modulo 2^16.
REQ-008 Final result is valid when state==19 (19 cycles after the first Computing cycle).
REQ-009 State saturation: state holds at 19 while Computing=1. After saturation the accumulators and result hold.
REQ-010 Computing=0: state, pipeline contents and accumulators hold (pause); compute resumes on re-assertion.
REQ-011 First compute cycle (state==0), accumulator seeding:
- load_old_output=1: acc[j] loads O[0] lane j.
- load_old_output=0: acc[j] holds its current value (PE_reset supplies zero).
REQ-012 When state reaches 19, the acc word is written to O[0].
REQ-013 result continuously mirrors acc.
REQ-014 Clear priority:
- Comp_reset clears state and the pipeline valid bits.
- Mem_Index_reset clears wp and rp.
- PE_reset clears acc.
- Each clear overrides any same-cycle increment.

Reset
REQ-015 Mem_reset_n=0 at a rising edge clears:
- all SRAM words, wp, rp, state, pipeline registers and acc.
- result therefore reads 0 and state reads 0.
REQ-016 Reset mid-compute aborts the computation. No O write occurs.

Configuration
REQ-017 Macro DOT_PRODUCT_DEBUG_EN:
- Defined: test_w carries wp per SRAM, test_r carries rp per SRAM, test_data carries the registered A/B read word.
- Undefined: test_r, test_w and test_data are tied to 0 (the ports remain).

Verification
REQ-018 Reset: Mem_reset_n=0 for 2 cycles -> result=0, state=0.
REQ-019 Load and compute:
- Load 8 words with A lanes=1, B lanes=2, O=0.
- Run PE_reset, then Computing for 19 cycles.
- Expected: result lanes = 16, state=19, O[0]=16.
REQ-020 Seeded compute: as REQ-019 with O[0] lanes=100 and load_old_output=1 -> result lanes = 116.
REQ-021 Wrap-around:
- Load A=255, B=255 in all 16 words; compute.
- Expected: each lane = (16*65025) mod 65536 = 57360.
REQ-022 Pause: deassert Computing for 3 cycles at state=5 -> state holds at 5; final result is identical to REQ-019.
REQ-023 Write-pointer wrap: 17 load cycles -> wp wraps to 1 and A[0] holds the 17th word (debug enabled).
